// File: rtl/spi_master_if.sv
// SPI master bus bundle: request/response handshake plus serial pins.
// The master modport is the controller side; slave is the user/bench side.
interface spi_master_if;
    logic       start;
    logic [7:0] din;
    logic       miso;
    logic       ss;
    logic       sck;
    logic       mosi;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    modport master (
        input  start, din, miso,
        output ss, sck, mosi, busy, done, dout
    );

    modport slave (
        output start, din, miso,
        input  ss, sck, mosi, busy, done, dout
    );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Frame: setup, 16 sck half-periods, hold, one-cycle done.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    spi_master_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [6:0] r_tx;
    logic [7:0] r_rx;
    logic       r_ss;
    logic       r_sck;
    logic       r_mosi;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_dout;
    logic       w_tick;

    // Divider expiry marks the end of the current sck phase.
    assign w_tick = (r_div == DIV_LAST);

    assign bus.ss   = r_ss;
    assign bus.sck  = r_sck;
    assign bus.mosi = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_dout;

    // Frame sequencer; every output comes straight from a register.
    // The msb of din goes out at acceptance, so only 7 tx bits remain.
    // In TRANSFER a low sck with bit counter 0 means all 8 rises
    // happened, so the trailing low phase ends the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= 8'h00;
            r_bit   <= 3'd0;
            r_tx    <= 7'h00;
            r_rx    <= 8'h00;
            r_ss    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx    <= bus.din[6:0];
                        r_mosi  <= bus.din[7];
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= 8'h00;
                        r_bit   <= 3'd0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_tick) begin
                        r_div   <= 8'h00;
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[6:0], bus.miso};
                        r_bit   <= r_bit + 3'd1;
                        r_state <= S_XFER;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_div <= 8'h00;
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            if (r_bit != 3'd0) begin
                                r_mosi <= r_tx[6];
                                r_tx   <= {r_tx[5:0], 1'b0};
                            end
                        end else if (r_bit == 3'd0) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[6:0], bus.miso};
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_div   <= 8'h00;
                        r_ss    <= 1'b1;
                        r_dout  <= r_rx;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master at CLK_DIV=4 and CLK_DIV=1.
// Expected bytes are queued at start and popped at each done pulse.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lb4 = 1'b1;
    logic miso1 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp4[$];
    logic [7:0] exp1[$];

    spi_master_if b4();
    spi_master_if b1();

    assign b4.miso = lb4 ? b4.mosi : 1'b0;
    assign b1.miso = miso1;

    spi_master #(.CLK_DIV(4)) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(b4)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    always #5 clk = ~clk;

    logic [1:0] m_ss, m_sck, m_mosi, m_busy, m_done;
    assign m_ss   = {b1.ss,   b4.ss};
    assign m_sck  = {b1.sck,  b4.sck};
    assign m_mosi = {b1.mosi, b4.mosi};
    assign m_busy = {b1.busy, b4.busy};
    assign m_done = {b1.done, b4.done};

    logic [1:0] p_ss = 2'b11;
    logic [1:0] p_sck = 2'b00;
    logic [1:0] p_mosi = 2'b00;
    logic [1:0] first = 2'b00;
    int rises[2] = '{0, 0};
    int dones[2] = '{0, 0};
    int viol[2] = '{0, 0};
    int busy_cyc[2] = '{0, 0};
    int setup_cnt[2] = '{0, 0};
    int low_cnt[2] = '{0, 0};
    logic [7:0] mseq = 8'h00;

    // Protocol monitor: counts edges/busy/done, tallies violations.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d;
            int bad;
            logic rise, fall, ssf, ssr;
            d    = (i == 0) ? 4 : 1;
            bad  = 0;
            rise = !p_sck[i] && m_sck[i];
            fall = p_sck[i] && !m_sck[i];
            ssf  = p_ss[i] && !m_ss[i];
            ssr  = !p_ss[i] && m_ss[i];
            p_ss[i]   <= m_ss[i];
            p_sck[i]  <= m_sck[i];
            p_mosi[i] <= m_mosi[i];
            if (!rst) begin
                if (m_busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
                if (m_done[i]) dones[i] <= dones[i] + 1;
                if (m_ss[i] && m_sck[i]) bad++;
                if (m_mosi[i] != p_mosi[i] && !fall && !ssf) bad++;
                if (ssf) begin
                    setup_cnt[i] <= 1;
                    first[i] <= 1'b1;
                end else if (first[i] && !m_sck[i]) begin
                    setup_cnt[i] <= setup_cnt[i] + 1;
                end
                if (rise) begin
                    rises[i] <= rises[i] + 1;
                    if (first[i] && setup_cnt[i] < d) bad++;
                    first[i] <= 1'b0;
                    if (i == 0) mseq <= {mseq[6:0], m_mosi[0]};
                end
                if (fall) low_cnt[i] <= 1;
                else if (!m_sck[i]) low_cnt[i] <= low_cnt[i] + 1;
                if (ssr && low_cnt[i] < d) bad++;
                viol[i] <= viol[i] + bad;
            end
        end
    end

    task automatic wait_done(input int which, output int n);
        n = 1;
        while (((which == 0) ? b4.done : b1.done) !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b4.ss !== 1'b1) begin
            errors++;
            $display("FAIL reset_ss4 got %b want 1", b4.ss);
        end
        checks++;
        if (b4.sck !== 1'b0) begin
            errors++;
            $display("FAIL reset_sck4 got %b want 0", b4.sck);
        end
        checks++;
        if (b4.mosi !== 1'b0) begin
            errors++;
            $display("FAIL reset_mosi4 got %b want 0", b4.mosi);
        end
        checks++;
        if ({b4.busy, b4.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_bd4 got %b want 00", {b4.busy, b4.done});
        end
        checks++;
        if (b4.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout4 got %h want 00", b4.dout);
        end
        checks++;
        if ({b1.ss, b1.sck, b1.busy, b1.dout} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL reset_dut1 got %b/%b/%b/%h want 1/0/0/00",
                     b1.ss, b1.sck, b1.busy, b1.dout);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loopback();
        int n, r0, bz0, d0;
        logic [7:0] e;
        lb4 = 1'b1;
        r0 = rises[0];
        bz0 = busy_cyc[0];
        d0 = dones[0];
        exp4.push_back(8'hA5);
        b4.din = 8'hA5;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        b4.din = 8'h00;
        wait_done(0, n);
        checks++;
        if (n != 73) begin
            errors++;
            $display("FAIL lb_latency got %0d want 73", n);
        end
        e = exp4.pop_front();
        checks++;
        if (b4.dout !== e) begin
            errors++;
            $display("FAIL lb_dout got %h want %h", b4.dout, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rises[0] - r0 != 8) begin
            errors++;
            $display("FAIL lb_rises got %0d want 8", rises[0] - r0);
        end
        checks++;
        if (mseq !== 8'hA5) begin
            errors++;
            $display("FAIL lb_mosi_seq got %b want 10100101", mseq);
        end
        checks++;
        if (busy_cyc[0] - bz0 != 73) begin
            errors++;
            $display("FAIL lb_busy got %0d want 73", busy_cyc[0] - bz0);
        end
        checks++;
        if (dones[0] - d0 != 1) begin
            errors++;
            $display("FAIL lb_dones got %0d want 1", dones[0] - d0);
        end
    endtask

    task automatic test_miso_high();
        int n, r0, bz0;
        logic [7:0] e;
        miso1 = 1'b1;
        r0 = rises[1];
        bz0 = busy_cyc[1];
        exp1.push_back(8'hFF);
        b1.din = 8'h00;
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        wait_done(1, n);
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL mh_latency got %0d want 19", n);
        end
        e = exp1.pop_front();
        checks++;
        if (b1.dout !== e) begin
            errors++;
            $display("FAIL mh_dout got %h want %h", b1.dout, e);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy_cyc[1] - bz0 != 19) begin
            errors++;
            $display("FAIL mh_busy got %0d want 19", busy_cyc[1] - bz0);
        end
        checks++;
        if (rises[1] - r0 != 8) begin
            errors++;
            $display("FAIL mh_rises got %0d want 8", rises[1] - r0);
        end
    endtask

    task automatic test_ignore();
        int n, d0;
        logic [7:0] e;
        lb4 = 1'b1;
        d0 = dones[0];
        exp4.push_back(8'hC3);
        b4.din = 8'hC3;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        b4.din = 8'h3C;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        wait_done(0, n);
        e = exp4.pop_front();
        checks++;
        if (b4.dout !== e) begin
            errors++;
            $display("FAIL ign_dout got %h want %h", b4.dout, e);
        end
        b4.din = 8'hFF;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (b4.busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_busy got %b want 0", b4.busy);
        end
        checks++;
        if (dones[0] - d0 != 1 || b4.dout !== 8'hC3) begin
            errors++;
            $display("FAIL ign_once got dones=%0d dout=%h want 1/c3",
                     dones[0] - d0, b4.dout);
        end
    endtask

    task automatic test_reset_mid();
        int n, k, w, d0;
        logic prev;
        logic [7:0] e;
        lb4 = 1'b1;
        d0 = dones[0];
        exp4.push_back(8'h96);
        b4.din = 8'h96;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        k = 0;
        w = 0;
        prev = b4.sck;
        while (k < 3 && w < 400) begin
            @(posedge clk);
            #1;
            w++;
            if (b4.sck && !prev) k++;
            prev = b4.sck;
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({b4.ss, b4.sck, b4.busy} !== 3'b100) begin
            errors++;
            $display("FAIL rm_abort got ss/sck/busy=%b want 100",
                     {b4.ss, b4.sck, b4.busy});
        end
        exp4.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b4.din = 8'h69;
        b4.start = 1'b1;
        exp4.push_back(8'h69);
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        checks++;
        if (b4.busy !== 1'b1 || b4.ss !== 1'b0) begin
            errors++;
            $display("FAIL rm_first_start got busy=%b ss=%b want 1/0",
                     b4.busy, b4.ss);
        end
        checks++;
        if (b4.dout !== 8'h00 || dones[0] != d0) begin
            errors++;
            $display("FAIL rm_no_done got dout=%h dones=%0d want 00/0",
                     b4.dout, dones[0] - d0);
        end
        wait_done(0, n);
        checks++;
        if (n != 73) begin
            errors++;
            $display("FAIL rm_latency got %0d want 73", n);
        end
        e = exp4.pop_front();
        checks++;
        if (b4.dout !== e) begin
            errors++;
            $display("FAIL rm_dout got %h want %h", b4.dout, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int n, g, d0;
        logic [7:0] e;
        lb4 = 1'b1;
        d0 = dones[0];
        repeat (3) exp4.push_back(8'h5A);
        b4.din = 8'h5A;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) begin
            wait_done(0, n);
            checks++;
            if (n != 73) begin
                errors++;
                $display("FAIL b2b_latency[%0d] got %0d want 73", t, n);
            end
            e = exp4.pop_front();
            checks++;
            if (b4.dout !== e) begin
                errors++;
                $display("FAIL b2b_dout[%0d] got %h want %h", t, b4.dout, e);
            end
            if (t == 2) b4.start = 1'b0;
            if (t < 2) begin
                g = 0;
                while (b4.ss && g < 50) begin
                    g++;
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (g < 1 || b4.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d] got gap=%0d busy=%b want >=1/1",
                             t, g, b4.busy);
                end
            end
        end
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (dones[0] - d0 != 3 || b4.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got dones=%0d busy=%b want 3/0",
                     dones[0] - d0, b4.busy);
        end
    endtask

    task automatic test_protocol();
        @(negedge clk);
        #1;
        checks++;
        if (viol[0] != 0) begin
            errors++;
            $display("FAIL proto_dut4 got %0d violations want 0", viol[0]);
        end
        checks++;
        if (viol[1] != 0) begin
            errors++;
            $display("FAIL proto_dut1 got %0d violations want 0", viol[1]);
        end
        checks++;
        if (exp4.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d/%0d want 0/0",
                     exp4.size(), exp1.size());
        end
    endtask

    initial begin
        b4.start = 1'b0;
        b4.din = 8'h00;
        b1.start = 1'b0;
        b1.din = 8'h00;
        test_reset();
        test_loopback();
        test_miso_high();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, half-period of sck in clk cycles (legal range 1..255).
REQ-002 clk  input  1  execution clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one 8-bit transfer; sampled only in IDLE.
REQ-005 din  input  8  byte to transmit, MSB first; captured when start is accepted.
REQ-006 miso  input  1  serial data from slave.
REQ-007 ss  output  1  slave select, active-low; high when no transfer is in progress.
REQ-008 sck  output  1  serial clock, idle low (CPOL=0, CPHA=0).
REQ-009 mosi  output  1  serial data to slave.
REQ-010 busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse marking transfer completion.
REQ-012 dout  output  8  byte received, MSB first; valid from the done cycle until the next accepted start.

Function
REQ-013 States: IDLE, SETUP, TRANSFER, HOLD, DONE; all outputs registered.
REQ-014 IDLE: ss=1, sck=0, busy=0, done=0; start=1 -> latch din into tx shift register, ss<=0, mosi<=din[7], busy<=1, clear divider and bit counter, go to SETUP.
REQ-015 SETUP: ss low, sck low for CLK_DIV cycles, then go to TRANSFER.
REQ-016 TRANSFER: sck toggles every CLK_DIV cycles; 8 rising and 8 falling edges total.
REQ-017 On each sck rising edge: miso shifted into rx register LSB; 3-bit bit counter increments.
REQ-018 On each sck falling edge except the 8th: mosi <= next tx bit (din[6] down to din[0]).
REQ-019 After the 8th falling edge (sck low): go to HOLD; sck stays low.
REQ-020 HOLD: ss low for CLK_DIV cycles, then ss<=1, dout<=rx register, go to DONE.
REQ-021 DONE: done=1, busy=1 for exactly one cycle; then IDLE.
REQ-022 Latency: done high exactly 18*CLK_DIV+1 cycles after the clk edge that accepted start.
REQ-023 start while not in IDLE (including the DONE cycle) is ignored; no queuing.
REQ-024 Back-to-back: start held high continuously begins the next transfer on the first IDLE cycle after done.
REQ-025 Bit counter wraps 7->0 only at transfer end; divider counter is 8 bits, reloaded each sck phase.
REQ-026 mosi holds its last value while in HOLD/DONE/IDLE; value in IDLE is don't-care but stable.
REQ-027 din changes after acceptance do not affect the transfer in progress.

Reset
REQ-028 While rst=1 (asynchronous): state=IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout=8'h00, shift registers and counters cleared.
REQ-029 rst asserted mid-transfer aborts immediately: ss high, sck low in same cycle; no done pulse; dout retains reset value 8'h00.
REQ-030 First start accepted on the first rising clk edge after rst deasserts.

Verification
REQ-031 Loopback (miso=mosi), CLK_DIV=4, din=8'hA5, start 1 cycle -> exactly 8 sck rising edges, mosi sequence 1,0,1,0,0,1,0,1, done 73 cycles after acceptance, dout=8'hA5.
REQ-032 miso tied 1, din=8'h00, CLK_DIV=1 -> done 19 cycles after acceptance, dout=8'hFF, busy high 19 cycles.
REQ-033 start pulsed again mid-transfer with din=8'h3C -> ignored; only one done, dout from the first transfer.
REQ-034 rst pulsed after 3rd sck rising edge -> ss=1, sck=0 immediately, no done, dout=8'h00; next start completes normally.
REQ-035 start held high, loopback, din=8'h5A -> consecutive transfers with ss high for at least 1 cycle between them; each done yields dout=8'h5A.
REQ-036 Protocol check on all tests: sck low whenever ss=1; mosi changes only on sck falling edges or at acceptance; at least CLK_DIV cycles from ss fall to first sck rise and from last sck fall to ss rise.
